// File: rtl/clb_config_ctrl.sv
// clb_config_ctrl: byte-serial configuration loader for the 4-CLB adder fabric.
// Receives a 4-byte frame {HDR, SEL, CEXT, CSUM} over a valid/ready handshake,
// validates it, and commits sel1..sel4 / C_external atomically.
// Optional build macro: CFG_TIMEOUT_EN enables an inter-byte stall timeout.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, committed outputs held
// HDR   | expecting header byte (HDR_BYTE)
// SEL   | expecting {sel4, sel3, sel2, sel1}
// CEXT  | expecting {7'b0, C_external}
// CSUM  | expecting SEL ^ CEXT, commit on match
// ERR   | one-cycle error state, config_err raised on entry
module clb_config_ctrl #(
  parameter logic [7:0] HDR_BYTE = 8'hA5
`ifdef CFG_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  output logic [1:0] sel3,
  output logic [1:0] sel4,
  output logic       C_external,
  output logic       busy,
  output logic       config_done,
  output logic       config_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] SEL  = 3'd2;
  localparam logic [2:0] CEXT = 3'd3;
  localparam logic [2:0] CSUM = 3'd4;
  localparam logic [2:0] ERR  = 3'd5;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       xfer;
  logic       commit;
  logic [7:0] sel_sh;
  logic       cext_sh;
  logic [7:0] csum;
  logic [7:0] sel_q;
  logic       cext_q;

  // reception states own the handshake; IDLE and ERR never accept a byte
  assign busy      = (state == HDR) || (state == SEL) || (state == CEXT) || (state == CSUM);
  assign cfg_ready = busy;
  assign xfer      = cfg_valid && cfg_ready;

  assign sel1       = sel_q[1:0];
  assign sel2       = sel_q[3:2];
  assign sel3       = sel_q[5:4];
  assign sel4       = sel_q[7:6];
  assign C_external = cext_q;

`ifdef CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // stall of TIMEOUT consecutive cycles without a transfer aborts the frame
  assign tmo_hit = busy && !xfer && (tmo_cnt == TW'(TIMEOUT - 1));

  // stall counter, cleared on every transfer and whenever not receiving
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt <= '0;
    end else if (!busy || xfer || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`endif

  // next-state decode and commit qualification
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = HDR;
      HDR:  if (xfer) state_nxt = (cfg_data == HDR_BYTE) ? SEL : ERR;
      SEL:  if (xfer) state_nxt = CEXT;
      CEXT: if (xfer) state_nxt = (cfg_data[7:1] != 7'd0) ? ERR : CSUM;
      CSUM: begin
        if (xfer) begin
          if (cfg_data == csum) begin
            state_nxt = IDLE;
            commit    = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef CFG_TIMEOUT_EN
    if (tmo_hit) state_nxt = ERR;
`endif
  end

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // shadow registers and running checksum, filled as bytes arrive
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_sh  <= 8'd0;
      cext_sh <= 1'b0;
      csum    <= 8'd0;
    end else if (xfer) begin
      if (state == SEL) begin
        sel_sh <= cfg_data;
        csum   <= cfg_data;
      end else if ((state == CEXT) && (cfg_data[7:1] == 7'd0)) begin
        cext_sh <= cfg_data[0];
        csum    <= csum ^ cfg_data;
      end
    end
  end

  // committed outputs change only on a fully validated frame, with the done pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q       <= 8'd0;
      cext_q      <= 1'b0;
      config_done <= 1'b0;
    end else begin
      config_done <= commit;
      if (commit) begin
        sel_q  <= sel_sh;
        cext_q <= cext_sh;
      end
    end
  end

  // sticky error: set entering ERR, cleared only by an accepted start
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      config_err <= 1'b0;
    end else if ((state == IDLE) && start) begin
      config_err <= 1'b0;
    end else if ((state_nxt == ERR) && (state != ERR)) begin
      config_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clb_config_ctrl.sv
// tb_clb_config_ctrl: scoreboard bench for clb_config_ctrl.
// Expected frame outcomes are pushed when a frame is driven and compared when
// the DUT leaves the reception states (commit, error or reset abort).
module tb_clb_config_ctrl;

  logic       CLK;
  logic       RST_N;
  logic       start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] sel1, sel2, sel3, sel4;
  logic       C_external;
  logic       busy;
  logic       config_done;
  logic       config_err;

  clb_config_ctrl dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .sel1        (sel1),
    .sel2        (sel2),
    .sel3        (sel3),
    .sel4        (sel4),
    .C_external  (C_external),
    .busy        (busy),
    .config_done (config_done),
    .config_err  (config_err)
  );

  typedef struct packed {
    logic [7:0] sel;
    logic       cext;
    logic       done;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_sel = 8'd0;
  logic       m_cext = 1'b0;
  bit         prev_busy = 1'b0;
  bit         done_low_chk = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // result monitor: sample mid-cycle, pop on every exit from reception
  always @(negedge CLK) begin
    exp_t e;
    if (done_low_chk) begin
      chk_eq("done_one_cycle", {31'd0, config_done}, 32'd0);
      done_low_chk = 1'b0;
    end
    if (prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_end", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk_eq("sel",        {24'd0, sel4, sel3, sel2, sel1}, {24'd0, e.sel});
        chk_eq("c_external", {31'd0, C_external}, {31'd0, e.cext});
        chk_eq("done",       {31'd0, config_done}, {31'd0, e.done});
        chk_eq("err",        {31'd0, config_err},  {31'd0, e.err});
        chk_eq("ready_off",  {31'd0, cfg_ready},   32'd0);
        if (e.done) done_low_chk = 1'b1;
      end
    end
    prev_busy = busy;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    cfg_data  = b;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!cfg_ready) chk_eq("ready_wait", 32'd0, 32'd1);
    @(posedge CLK); #1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
  endtask

  // reference model: walk the frame bytes and derive the outcome
  task automatic push_expect(input logic [7:0] b0, b1, b2, b3, input bit tmo);
    exp_t e;
    e.err  = 1'b1;
    e.done = 1'b0;
    if (!tmo && b0 == 8'hA5 && b2[7:1] == 7'd0 && b3 == (b1 ^ b2)) begin
      m_sel  = b1;
      m_cext = b2[0];
      e.err  = 1'b0;
      e.done = 1'b1;
    end
    e.sel  = m_sel;
    e.cext = m_cext;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk_eq("result_wait", 32'd0, 32'd1);
      exp_q.delete();
    end
    repeat (2) begin @(posedge CLK); #1; end
  endtask

  // drive one frame: nb bytes, optional stall of gap cycles after B1
  task automatic frame(input logic [7:0] b0, b1, b2, b3, input int nb, input int gap, input bit tmo);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    push_expect(b0, b1, b2, b3, tmo);
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    chk_eq("err_clear_on_start", {31'd0, config_err}, 32'd0);
    for (int i = 0; i < nb; i++) begin
      send_byte(bytes[i]);
      if (i == 1 && gap > 0) begin
        for (int k = 0; k < gap; k++) begin
          start = (k == 2);
          @(posedge CLK); #1;
        end
        start = 1'b0;
      end
    end
    wait_drain();
  endtask

  initial begin
    logic [7:0] r1, r2, r3;
    RST_N     = 1'b0;
    start     = 1'b0;
    cfg_data  = 8'h00;
    cfg_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_eq("rst_sel",   {24'd0, sel4, sel3, sel2, sel1}, 32'd0);
    chk_eq("rst_cext",  {31'd0, C_external}, 32'd0);
    chk_eq("rst_ready", {31'd0, cfg_ready}, 32'd0);
    chk_eq("rst_busy",  {31'd0, busy}, 32'd0);
    chk_eq("rst_done",  {31'd0, config_done}, 32'd0);
    chk_eq("rst_err",   {31'd0, config_err}, 32'd0);
    RST_N = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end

    // idle with cfg_valid does nothing
    cfg_valid = 1'b1; cfg_data = 8'hA5;
    @(posedge CLK); #1;
    chk_eq("idle_busy", {31'd0, busy}, 32'd0);
    cfg_valid = 1'b0;

    frame(8'hA5, 8'h1B, 8'h01, 8'h1A, 4, 0, 1'b0);
    frame(8'hA4, 8'h1B, 8'h01, 8'h1A, 1, 0, 1'b0);
    frame(8'hA5, 8'hE4, 8'h00, 8'h00, 4, 0, 1'b0);
    frame(8'hA5, 8'hE4, 8'h00, 8'hE4, 4, 0, 1'b0);
    frame(8'hA5, 8'h00, 8'h02, 8'h02, 3, 0, 1'b0);
    frame(8'hA5, 8'h1B, 8'h01, 8'h1A, 4, 5, 1'b0);

    // reset mid-frame after B1
    exp_q.push_back(exp_t'{sel: 8'd0, cext: 1'b0, done: 1'b0, err: 1'b0});
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h6C);
    RST_N = 1'b0;
    #2;
    chk_eq("mid_rst_sel",  {24'd0, sel4, sel3, sel2, sel1}, 32'd0);
    chk_eq("mid_rst_cext", {31'd0, C_external}, 32'd0);
    chk_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    m_sel  = 8'd0;
    m_cext = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    wait_drain();

    // randomized frames, some with corrupted checksum
    for (int it = 0; it < 8; it++) begin
      r1 = 8'($urandom);
      r2 = {7'd0, 1'($urandom)};
      r3 = (r1 ^ r2) ^ (($urandom_range(0, 3) == 0) ? 8'h40 : 8'h00);
      frame(8'hA5, r1, r2, r3, 4, 0, 1'b0);
    end

`ifdef CFG_TIMEOUT_EN
    frame(8'hA5, 8'h39, 8'h01, 8'h38, 2, 16, 1'b1);
    frame(8'hA5, 8'h39, 8'h01, 8'h38, 4, 15, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
